demux_dest: RTL and testbench

Destination demultiplexer for the two-virtual-channel datapath. It is the receiving end of the VC0/VC1 merge. It takes the single merged word stream, buffers one word, and routes each word to one of two downstream FIFOs (D0, D1) by a destination bit carried in the word. Downstream FIFO full flags produce backpressure toward the sender, and the block keeps a delivered-word count per destination.

---
 rtl/vc_pkg.sv | 13 +
 rtl/demux_dest_if.sv | 33 +++
 rtl/dest_counter.sv | 23 ++
 rtl/demux_dest.sv | 79 +++++++
 tb/tb_demux_dest.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/vc_pkg.sv
// Shared encodings for the two-virtual-channel datapath: holding-stage
// FSM states and destination selector values.
package vc_pkg;

    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } state_t;

    localparam logic DEST_D0 = 1'b0;
    localparam logic DEST_D1 = 1'b1;

endpackage

// File: rtl/demux_dest_if.sv
// Bus bundle between the merged VC stream, the destination demux and the
// two downstream FIFOs. The demux is the slave; the surroundings are the master.
interface demux_dest_if #(
    parameter int DATA_SIZE = 4,
    parameter int CNT_WIDTH = 4
) ();

    logic                 valid_in;
    logic [DATA_SIZE-1:0] data_in;
    logic                 ready_out;
    logic                 full_d0;
    logic                 full_d1;
    logic                 push_d0;
    logic [DATA_SIZE-1:0] data_d0;
    logic                 push_d1;
    logic [DATA_SIZE-1:0] data_d1;
    logic [CNT_WIDTH-1:0] count_d0;
    logic [CNT_WIDTH-1:0] count_d1;
    logic                 idle;

    modport slave (
        input  valid_in, data_in, full_d0, full_d1,
        output ready_out, push_d0, data_d0, push_d1, data_d1,
               count_d0, count_d1, idle
    );

    modport master (
        output valid_in, data_in, full_d0, full_d1,
        input  ready_out, push_d0, data_d0, push_d1, data_d1,
               count_d0, count_d1, idle
    );

endinterface

// File: rtl/dest_counter.sv
// Wrapping delivered-word counter for one destination.
module dest_counter #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/demux_dest.sv
// Destination demultiplexer: one-word holding stage that routes each word to
// D0 or D1 by its destination bit, with full-flag backpressure and counters.
module demux_dest #(
    parameter int DATA_SIZE = 4,
    parameter int DEST_BIT  = 3,
    parameter int CNT_WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset_L,
    demux_dest_if.slave   bus
);

    import vc_pkg::*;

    state_t               state_reg;
    logic [DATA_SIZE-1:0] held_data_reg;
    logic                 push_reg [2];
    logic [DATA_SIZE-1:0] data_reg [2];
    logic [CNT_WIDTH-1:0] cnt      [2];
    logic [1:0]           inc;

    logic tgt_dest;
    logic tgt_full;
    logic issue;
    logic ready;
    logic accept;

    assign tgt_dest = held_data_reg[DEST_BIT];
    assign tgt_full = (tgt_dest == DEST_D1) ? bus.full_d1 : bus.full_d0;
    assign issue    = (state_reg == LOADED) && !tgt_full;
    // Ready deliberately ignores valid_in so the sender never sees a loop.
    assign ready    = (state_reg == EMPTY) || issue;
    assign accept   = bus.valid_in && ready;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_reg     <= EMPTY;
            held_data_reg <= '0;
            for (int i = 0; i < 2; i++) begin
                push_reg[i] <= 1'b0;
                data_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                push_reg[i] <= issue && (tgt_dest == 1'(i));
                data_reg[i] <= (issue && (tgt_dest == 1'(i))) ? held_data_reg : '0;
            end
            if (accept) begin
                state_reg     <= LOADED;
                held_data_reg <= bus.data_in;
            end else if (issue) begin
                state_reg     <= EMPTY;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            assign inc[gi] = issue && (tgt_dest == 1'(gi));
            dest_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
                .clk     (clk),
                .reset_L (reset_L),
                .inc     (inc[gi]),
                .count   (cnt[gi])
            );
        end
    endgenerate

    assign bus.ready_out = ready;
    assign bus.idle      = (state_reg == EMPTY);
    assign bus.push_d0   = push_reg[0];
    assign bus.data_d0   = data_reg[0];
    assign bus.push_d1   = push_reg[1];
    assign bus.data_d1   = data_reg[1];
    assign bus.count_d0  = cnt[0];
    assign bus.count_d1  = cnt[1];

endmodule

// File: tb/tb_demux_dest.sv
// Self-checking bench for demux_dest: a queue-based delivery model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_demux_dest;

    localparam int DATA_SIZE = 4;
    localparam int DEST_BIT  = 3;
    localparam int CNT_WIDTH = 4;

    logic clk     = 1'b0;
    logic reset_L = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    demux_dest_if #(.DATA_SIZE(DATA_SIZE), .CNT_WIDTH(CNT_WIDTH)) bus ();

    demux_dest #(.DATA_SIZE(DATA_SIZE), .DEST_BIT(DEST_BIT), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: at most one word waits; it leaves when its FIFO is not full.
    logic [DATA_SIZE-1:0] held_q[$];
    logic                 exp_push [2];
    logic [DATA_SIZE-1:0] exp_data [2];
    int                   exp_cnt  [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            exp_push[i] = 1'b0;
            exp_data[i] = '0;
            exp_cnt[i]  = 0;
        end
    end

    function automatic logic blocked(input logic [DATA_SIZE-1:0] w);
        return w[DEST_BIT] ? bus.full_d1 : bus.full_d0;
    endfunction

    function automatic logic model_ready();
        return (held_q.size() == 0) || !blocked(held_q[0]);
    endfunction

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            held_q.delete();
            for (int i = 0; i < 2; i++) begin
                exp_push[i] = 1'b0;
                exp_data[i] = '0;
                exp_cnt[i]  = 0;
            end
        end else begin
            logic                 go;
            logic                 take;
            logic [DATA_SIZE-1:0] w;
            go   = (held_q.size() != 0) && !blocked(held_q[0]);
            take = bus.valid_in && model_ready();
            for (int i = 0; i < 2; i++) begin
                exp_push[i] = 1'b0;
                exp_data[i] = '0;
            end
            if (go) begin
                w = held_q.pop_front();
                exp_push[w[DEST_BIT]] = 1'b1;
                exp_data[w[DEST_BIT]] = w;
                exp_cnt[w[DEST_BIT]]  = (exp_cnt[w[DEST_BIT]] + 1) % (1 << CNT_WIDTH);
            end
            if (take) held_q.push_back(bus.data_in);
        end
    end

    bit compare_en = 1'b0;

    always @(negedge clk) begin
        if (compare_en) begin
            chk("ready_out", bus.ready_out, model_ready());
            chk("idle",      bus.idle,      held_q.size() == 0);
            chk("push_d0",   bus.push_d0,   exp_push[0]);
            chk("data_d0",   bus.data_d0,   exp_data[0]);
            chk("push_d1",   bus.push_d1,   exp_push[1]);
            chk("data_d1",   bus.data_d1,   exp_data[1]);
            chk("count_d0",  bus.count_d0,  exp_cnt[0]);
            chk("count_d1",  bus.count_d1,  exp_cnt[1]);
            chk("one_push",  bus.push_d0 && bus.push_d1, 1'b0);
        end
    end

    // Drive inputs, then let one rising edge pass; returns 2 time units after it.
    task automatic step(input logic v, input logic [DATA_SIZE-1:0] d,
                        input logic f0, input logic f1);
        bus.valid_in = v;
        bus.data_in  = d;
        bus.full_d0  = f0;
        bus.full_d1  = f1;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_L      = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.full_d0  = 1'b0;
        bus.full_d1  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        reset_L = 1'b1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [DATA_SIZE-1:0] w;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.full_d0  = 1'b0;
        bus.full_d1  = 1'b0;
        @(posedge clk);
        #1;
        compare_en = 1'b1;
        do_reset();

        // Reset then idle
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);
        chk("idle_push_d0", bus.push_d0, 1'b0);
        chk("idle_push_d1", bus.push_d1, 1'b0);
        chk("idle_cnt_d0",  bus.count_d0, 0);
        chk("idle_ready",   bus.ready_out, 1'b1);
        chk("idle_idle",    bus.idle, 1'b1);

        // Single word to D1
        step(1'b1, 4'b1010, 1'b0, 1'b0);
        chk("single_held", bus.idle, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("single_push_d1", bus.push_d1, 1'b1);
        chk("single_data_d1", bus.data_d1, 4'b1010);
        chk("single_push_d0", bus.push_d0, 1'b0);
        chk("single_cnt_d1",  bus.count_d1, 1);

        // Alternating stream
        do_reset();
        for (int i = 0; i < 8; i++) begin
            w = 4'((i % 2) * 8 + i / 2);
            step(1'b1, w, 1'b0, 1'b0);
            chk("stream_ready", bus.ready_out, 1'b1);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("stream_cnt_d0", bus.count_d0, 4);
        chk("stream_cnt_d1", bus.count_d1, 4);

        // Backpressure on D0, D1 full toggling is irrelevant
        do_reset();
        step(1'b1, 4'h2, 1'b0, 1'b0);
        step(1'b1, 4'h5, 1'b1, 1'b0);
        chk("bp_ready_1", bus.ready_out, 1'b0);
        step(1'b1, 4'h5, 1'b1, 1'b1);
        chk("bp_ready_2", bus.ready_out, 1'b0);
        chk("bp_nopush_2", bus.push_d0, 1'b0);
        step(1'b1, 4'h5, 1'b1, 1'b0);
        chk("bp_ready_3", bus.ready_out, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("bp_push_d0", bus.push_d0, 1'b1);
        chk("bp_data_d0", bus.data_d0, 4'h2);
        chk("bp_cnt_d0",  bus.count_d0, 1);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 4'(8 + (i % 8)), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("wrap_cnt_d1", bus.count_d1, 1);

        // Mid-stream asynchronous reset with a pending push and a held word
        do_reset();
        step(1'b1, 4'hC, 1'b0, 1'b0);
        step(1'b1, 4'hD, 1'b0, 1'b0);
        bus.valid_in = 1'b0;
        #1;
        reset_L = 1'b0;
        #1;
        chk("rst_push_d1", bus.push_d1, 1'b0);
        chk("rst_data_d1", bus.data_d1, 4'h0);
        chk("rst_idle",    bus.idle, 1'b1);
        chk("rst_ready",   bus.ready_out, 1'b1);
        chk("rst_cnt_d1",  bus.count_d1, 0);
        @(negedge clk);
        #1;
        reset_L = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0);
        chk("rst_after_cnt", bus.count_d1, 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);

        compare_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
